// File: rtl/slice_accum_pkg.sv
`default_nettype none
// ============================================================================
// Module   : slice_accum_pkg
// Brief    : Shared constants and overflow-resolve helper for slice_accum_pipe.
// Revision : 1.0
// ============================================================================
package slice_accum_pkg;

    localparam int ACC_WRAP = 0;
    localparam int ACC_SAT  = 1;

    typedef enum logic [1:0] {
        RES_NONE = 2'd0,
        RES_WRAP = 2'd1,
        RES_SAT  = 2'd2
    } resolve_e;

    // Takes the three carry bits above ACC_W of an ACC_W+3-bit sum; the low
    // ACC_W bits are the wrapped value, so only the action is returned.
    function automatic resolve_e resolve_ovf(input logic [2:0] carry, input int mode);
        if (carry == 3'b000) begin
            return RES_NONE;
        end else if (mode == ACC_SAT) begin
            return RES_SAT;
        end else begin
            return RES_WRAP;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/slice_accum_bank.sv
`default_nettype none
// ============================================================================
// Module   : slice_accum_bank
// Brief    : Per-channel accumulator registers and sticky overflow flags with
//            one read/modify/write port and a clear port (clear wins first).
// Revision : 1.0
// ============================================================================
module slice_accum_bank
    import slice_accum_pkg::*;
#(
    parameter int ACC_W  = 32,
    parameter int NUM_CH = 4,
    parameter int CH_W   = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wr_en,
    input  logic [CH_W-1:0]   i_ch,
    input  logic [ACC_W-1:0]  i_wr_data,
    input  logic              i_wr_ovf,
    output logic [ACC_W-1:0]  o_rd_data,
    input  logic              i_clr_en,
    input  logic [CH_W-1:0]   i_clr_ch,
    output logic [NUM_CH-1:0] o_sticky
);

    logic [ACC_W-1:0]  r_acc [NUM_CH];
    logic [NUM_CH-1:0] r_sticky;
    logic              w_clr_hit;
    logic              w_sticky_base;

    // A clear on the channel being updated makes the update see a zero base.
    assign w_clr_hit     = i_clr_en && (i_clr_ch == i_ch);
    assign o_rd_data     = w_clr_hit ? '0 : r_acc[i_ch];
    assign w_sticky_base = w_clr_hit ? 1'b0 : r_sticky[i_ch];
    assign o_sticky      = r_sticky;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_acc[i] <= '0;
            end
            r_sticky <= '0;
        end else begin
            if (i_clr_en) begin
                r_acc[i_clr_ch]    <= '0;
                r_sticky[i_clr_ch] <= 1'b0;
            end
            if (i_wr_en) begin
                r_acc[i_ch]    <= i_wr_data;
                r_sticky[i_ch] <= w_sticky_base | i_wr_ovf;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/slice_accum_pipe.sv
`default_nettype none
// ============================================================================
// Module   : slice_accum_pipe
// Brief    : Two-stage valid/ready slice-and-accumulate engine over NUM_CH
//            channels with wrap or saturate overflow handling.
// Revision : 1.0
// ============================================================================
module slice_accum_pipe
    import slice_accum_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ACC_W     = 32,
    parameter int SLICE_LSB = 4,
    parameter int SLICE_W   = 4,
    parameter int NUM_CH    = 4,
    parameter int SAT_MODE  = ACC_WRAP,
    parameter int CH_W      = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CH_W-1:0]   in_ch,
    input  logic [DATA_W-1:0] in_bus,
    input  logic              in_gate,
    input  logic [ACC_W-1:0]  in_x,
    input  logic [ACC_W-1:0]  in_y,
    input  logic              clr_valid,
    input  logic [CH_W-1:0]   clr_ch,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH_W-1:0]   out_ch,
    output logic [ACC_W-1:0]  out_acc,
    output logic              out_ovf,
    output logic [NUM_CH-1:0] ovf_sticky
);

    localparam int SUM_W = ACC_W + 2;
    localparam int T_W   = ACC_W + 3;

    logic               r_s1_valid;
    logic [CH_W-1:0]    r_s1_ch;
    logic [SUM_W-1:0]   r_s1_sum;
    logic               r_out_valid;
    logic [CH_W-1:0]    r_out_ch;
    logic [ACC_W-1:0]   r_out_acc;
    logic               r_out_ovf;

    logic               w_advance;
    logic               w_accept;
    logic [SLICE_W-1:0] w_gated;
    logic [SUM_W-1:0]   w_sum;
    logic [ACC_W-1:0]   w_acc_rd;
    logic [T_W-1:0]     w_t;
    resolve_e           w_res;
    logic               w_ovf;
    logic [ACC_W-1:0]   w_new_acc;

    assign w_advance = r_s1_valid && (!r_out_valid || out_ready);
    assign in_ready  = !r_s1_valid || w_advance;
    assign w_accept  = in_valid && in_ready;

    assign w_gated = in_gate ? in_bus[SLICE_LSB +: SLICE_W] : '0;
    assign w_sum   = SUM_W'(in_x) + SUM_W'(in_y) + SUM_W'(in_bus) + SUM_W'(w_gated);

    // The accumulator is read and written only here, so same-channel
    // back-to-back updates always see the previous result.
    assign w_t       = T_W'(w_acc_rd) + T_W'(r_s1_sum);
    assign w_res     = resolve_ovf(w_t[T_W-1:ACC_W], SAT_MODE);
    assign w_ovf     = (w_res != RES_NONE);
    assign w_new_acc = (w_res == RES_SAT) ? '1 : w_t[ACC_W-1:0];

    slice_accum_bank #(
        .ACC_W  (ACC_W),
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (w_advance),
        .i_ch      (r_s1_ch),
        .i_wr_data (w_new_acc),
        .i_wr_ovf  (w_ovf),
        .o_rd_data (w_acc_rd),
        .i_clr_en  (clr_valid),
        .i_clr_ch  (clr_ch),
        .o_sticky  (ovf_sticky)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_ch    <= '0;
            r_s1_sum   <= '0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_ch    <= in_ch;
            r_s1_sum   <= w_sum;
        end else if (w_advance) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_out_acc   <= '0;
            r_out_ovf   <= 1'b0;
        end else if (w_advance) begin
            r_out_valid <= 1'b1;
            r_out_ch    <= r_s1_ch;
            r_out_acc   <= w_new_acc;
            r_out_ovf   <= w_ovf;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_ch    = r_out_ch;
    assign out_acc   = r_out_acc;
    assign out_ovf   = r_out_ovf;

endmodule
`default_nettype wire
